// File: rtl/amber128_pkg.sv
// Shared core types and constants for the amber128 register-file path.
package amber128_pkg;

    localparam int DATA_REG_AW = 5;
    localparam int D_XLEN      = 128;

    localparam logic [DATA_REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DATA_REG_AW-1:0] addr;
        logic [D_XLEN-1:0]      data;
    } amber128_wb_req_s;

    // True when two or more bits of v are set.
    function automatic logic multi_hot(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(v[i]);
        end
        return (n >= 2);
    endfunction

endpackage

// File: rtl/amber128_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr_i, wrapping.
// Zero latency; grant_vld_o low and grant_o all-zero when nothing is eligible.
module amber128_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_vld_o
);

    int idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        idx         = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_vld_o && eligible_i[idx]) begin
                grant_vld_o  = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/amber128_wb_arbiter.sv
// Round-robin share of the regfile write port; accepted write drives wr_* one cycle later.
// ready is a same-cycle one-hot grant; freeze_i withholds all grants.
module amber128_wb_arbiter
    import amber128_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic             [NUM_REQ-1:0]      req_valid_i,
    input  amber128_wb_req_s [NUM_REQ-1:0]      req_i,
    output logic             [NUM_REQ-1:0]      req_ready_o,
    input  logic                                freeze_i,
    input  logic                                clr_cnt_i,
    output logic                                wr_en_o,
    output logic             [DATA_REG_AW-1:0]  wr_addr_o,
    output logic             [D_XLEN-1:0]       wr_data_o,
    output logic             [CNT_W-1:0]        conflict_cnt_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_vld;
    logic                   conflict;
    amber128_wb_req_s       sel_req;

    logic                   wr_en_q,   wr_en_d;
    logic [DATA_REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [D_XLEN-1:0]      wr_data_q, wr_data_d;
    logic [IDX_W-1:0]       rr_ptr_q,  rr_ptr_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;

    assign eligible = req_valid_i & {NUM_REQ{~freeze_i}};
    assign conflict = multi_hot(8'(eligible));

    amber128_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .eligible_i  (eligible),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    assign req_ready_o = grant;
    assign sel_req     = req_i[grant_idx];

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;

        // Grants only go to valid requesters, so a grant is an acceptance.
        if (grant_vld) begin
            wr_en_d   = (sel_req.addr != REG_ZERO);
            wr_addr_d = sel_req.addr;
            wr_data_d = sel_req.data;
            rr_ptr_d  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end

        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (conflict && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign conflict_cnt_o = cnt_q;

endmodule
